bt656_rx: RTL
=============

BT656_RX -- requirements
Module: bt656_rx

Interface
REQ-001 SHALL have parameter HACT_PIXELS, default 1440: expected active bytes per line between SAV and EAV.
REQ-002 SHALL have parameter LOCK_LINES, default 2: consecutive good EAVs needed to assert lock.
REQ-003 SHALL have port i_SysClock, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_ResetN, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port i_DataEn, input, 1: byte strobe; i_Data is accepted only in cycles where i_DataEn=1.
REQ-006 SHALL have port i_Data, input, 8: BT.656 byte stream.
REQ-007 SHALL have port o_Data, output, 8: active-video byte.
REQ-008 SHALL have port o_DataValid, output, 1: o_Data qualifier.
REQ-009 SHALL have ports o_Fsignal, o_Vsignal and o_Hsignal, output, 1 each: last decoded F, V and H flags.
REQ-010 SHALL have port o_LineCount, output, 16: active-line index within the field.
REQ-011 SHALL have port o_PixelCount, output, 16: active bytes received so far in the current line.
REQ-012 SHALL have port o_Locked, output, 1: stream lock indicator.
REQ-013 SHALL have ports o_CodeError and o_LenError, output, 1 each: single-cycle error pulses.

Function
REQ-014 SHALL run a TRS detector FSM with states SEEK, GOT_FF, GOT_00, GOT_0000, advancing only on accepted bytes.
REQ-015 SHALL use these transitions: SEEK -FF-> GOT_FF; GOT_FF -00-> GOT_00; GOT_00 -00-> GOT_0000; GOT_0000 -any-> SEEK, where that byte is XY.
REQ-016 SHALL move to GOT_FF on any FF byte received in GOT_00 or GOT_0000, and to SEEK on any other mismatch.
REQ-017 SHALL decode XY as bit7=1, F=bit6, V=bit5, H=bit4, with P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
REQ-018 SHALL treat an XY byte as valid only if bit7=1 and syndrome = XY[3:0] ^ expected P equals 0.
REQ-019 SHALL, on a valid XY, update o_Fsignal, o_Vsignal and o_Hsignal one cycle after XY acceptance.
REQ-020 SHALL, on an invalid XY, pulse o_CodeError for 1 cycle, leave the flags unchanged and clear o_Locked.
REQ-021 SHALL enter the active-video region on a valid SAV (H=0) with V=0.
REQ-022 SHALL leave the active-video region when an FF byte is accepted, since video bytes are restricted to 01..FE.
REQ-023 SHALL, for each byte accepted in the active region, present it on o_Data with o_DataValid=1 exactly one cycle after acceptance; otherwise o_DataValid=0.
REQ-024 SHALL increment o_PixelCount per active byte and clear it on each valid SAV; the count saturates at FFFF.
REQ-025 SHALL, on a valid EAV (H=1), compare the count against HACT_PIXELS only if the preceding SAV had V=0.
REQ-026 SHALL, on an EAV length mismatch, pulse o_LenError and clear o_Locked and the good-line counter.
REQ-027 SHALL increment o_LineCount after each good EAV with V=0.
REQ-028 SHALL clear o_LineCount on the first valid code with V=1 after V=0, and on any F change; the count wraps at 16 bits.
REQ-029 SHALL increment the good-line counter on each EAV with correct length, and assert o_Locked when it reaches LOCK_LINES.
REQ-030 SHALL give a code error priority if a code error and a lock increment occur in the same cycle, so that lock is cleared.
REQ-031 SHALL hold all state and outputs while i_DataEn=0, except that pulses and o_DataValid drop to 0.

Reset
REQ-032 SHALL, while i_ResetN=0 at a clock edge, set the FSM to SEEK, clear the active region, and set every output to 0 (o_Data=00).
REQ-033 SHALL, on reset mid-line, discard the partial line and output no data until the next valid SAV.

Configuration
REQ-034 SHALL, when macro BT656_RX_ECC_EN is defined, correct single-bit XY errors by syndrome:
- 0111 flips F
- 1011 flips V
- 1101 flips H
- single-bit syndromes flip that P bit only
- a corrected XY is treated as valid with no o_CodeError
- any other nonzero syndrome is uncorrectable.
REQ-035 SHALL, when BT656_RX_ECC_EN is undefined, treat any nonzero syndrome as invalid (REQ-020).

Verification
REQ-036 SHALL verify, with HACT_PIXELS=4: FF 00 00 80, 10 20 30 40, FF 00 00 9D -> o_Data 10,20,30,40 each 1 cycle after input, V=0, H=1 after 9D, o_PixelCount=4, no errors.
REQ-037 SHALL verify: two good lines as above -> o_Locked=1 after second 9D; then a line with 3 bytes -> o_LenError pulse, o_Locked=0.
REQ-038 SHALL verify: FF 00 00 AB, 55 55, FF 00 00 B6 -> o_Vsignal=1, o_DataValid stays 0, o_LineCount=0.
REQ-039 SHALL verify: SAV byte 81 instead of 80 -> with ECC_EN, active video is entered and there is no error; without it, an o_CodeError pulse and no o_DataValid.
REQ-040 SHALL verify: FF 00 FF 00 00 80, then a byte gap with i_DataEn=0 for 5 cycles -> SAV is still detected and the FSM is frozen during the gap.
REQ-041 SHALL verify: i_ResetN=0 after 2 active bytes -> all outputs are 0; after release, the bytes 77 77 produce no o_DataValid until FF 00 00 80.

Source files
------------

// File: rtl/bt656_rx.sv
// BT.656 receiver: finds TRS codes, decodes the F/V/H flags, passes active video and tracks line lock.
// Define BT656_RX_ECC_EN to correct single-bit errors in the XY status byte.
module bt656_rx #(
    parameter int HACT_PIXELS = 1440,
    parameter int LOCK_LINES  = 2
) (
    input  logic        i_SysClock,
    input  logic        i_ResetN,
    input  logic        i_DataEn,
    input  logic [7:0]  i_Data,
    output logic [7:0]  o_Data,
    output logic        o_DataValid,
    output logic        o_Fsignal,
    output logic        o_Vsignal,
    output logic        o_Hsignal,
    output logic [15:0] o_LineCount,
    output logic [15:0] o_PixelCount,
    output logic        o_Locked,
    output logic        o_CodeError,
    output logic        o_LenError,
    output logic [1:0]  o_TrsState
);

    localparam logic [15:0] HACT_L = 16'(HACT_PIXELS);
    localparam logic [15:0] LOCK_L = 16'(LOCK_LINES);

    typedef enum logic [1:0] {SEEK, GOT_FF, GOT_00, GOT_0000} trs_state_e;

    trs_state_e  state_q, state_d;
    logic        xy_strobe;

    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        f_q, f_d, v_q, v_d, h_q, h_d;
    logic [15:0] line_q, line_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] good_q, good_d;
    logic        locked_q, locked_d;
    logic        code_err_q, code_err_d;
    logic        len_err_q, len_err_d;
    logic        active_q, active_d;
    logic        sav_v0_q, sav_v0_d;

    logic        dec_f, dec_v, dec_h;
    logic [3:0]  p_exp, syndrome;
    logic        syn_ok, xy_valid, xy_bad;
    logic        line_clr, line_inc;
    logic [15:0] good_inc;

    // TRS detector; only accepted bytes move it
    always_comb begin
        state_d   = state_q;
        xy_strobe = 1'b0;
        if (i_DataEn) begin
            case (state_q)
                SEEK:     state_d = (i_Data == 8'hFF) ? GOT_FF : SEEK;
                GOT_FF:   state_d = (i_Data == 8'h00) ? GOT_00 : SEEK;
                GOT_00: begin
                    if (i_Data == 8'h00)      state_d = GOT_0000;
                    else if (i_Data == 8'hFF) state_d = GOT_FF;
                    else                      state_d = SEEK;
                end
                GOT_0000: begin
                    xy_strobe = 1'b1;
                    state_d   = (i_Data == 8'hFF) ? GOT_FF : SEEK;
                end
                default:  state_d = SEEK;
            endcase
        end
    end

    // XY decode; the syndrome pattern pinpoints which flag or parity bit flipped
    always_comb begin
        dec_f    = i_Data[6];
        dec_v    = i_Data[5];
        dec_h    = i_Data[4];
        p_exp    = {i_Data[5] ^ i_Data[4], i_Data[6] ^ i_Data[4],
                    i_Data[6] ^ i_Data[5], i_Data[6] ^ i_Data[5] ^ i_Data[4]};
        syndrome = i_Data[3:0] ^ p_exp;
`ifdef BT656_RX_ECC_EN
        syn_ok = 1'b1;
        case (syndrome)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: syn_ok = 1'b1;
            4'b0111: dec_f = ~i_Data[6];
            4'b1011: dec_v = ~i_Data[5];
            4'b1101: dec_h = ~i_Data[4];
            default: syn_ok = 1'b0;
        endcase
`else
        syn_ok = (syndrome == 4'b0000);
`endif
        xy_valid = xy_strobe && i_Data[7] && syn_ok;
        xy_bad   = xy_strobe && !(i_Data[7] && syn_ok);
    end

    always_comb begin
        data_d     = data_q;
        dv_d       = 1'b0;
        f_d        = f_q;
        v_d        = v_q;
        h_d        = h_q;
        pix_d      = pix_q;
        good_d     = good_q;
        locked_d   = locked_q;
        code_err_d = 1'b0;
        len_err_d  = 1'b0;
        active_d   = active_q;
        sav_v0_d   = sav_v0_q;
        line_clr   = 1'b0;
        line_inc   = 1'b0;
        good_inc   = (good_q < LOCK_L) ? good_q + 16'd1 : good_q;

        // FF never occurs in video, so it always ends the active region
        if (i_DataEn && active_q && i_Data != 8'hFF) begin
            data_d = i_Data;
            dv_d   = 1'b1;
            pix_d  = (pix_q == 16'hFFFF) ? pix_q : pix_q + 16'd1;
        end
        if (i_DataEn && i_Data == 8'hFF) active_d = 1'b0;

        if (xy_bad) begin
            code_err_d = 1'b1;
            locked_d   = 1'b0;
            good_d     = 16'd0;
        end

        if (xy_valid) begin
            f_d = dec_f;
            v_d = dec_v;
            h_d = dec_h;
            if (dec_f != f_q || (dec_v && !v_q)) line_clr = 1'b1;
            if (!dec_h) begin
                active_d = !dec_v;
                sav_v0_d = !dec_v;
                pix_d    = 16'd0;
            end else begin
                sav_v0_d = 1'b0;
                if (sav_v0_q) begin
                    if (pix_q == HACT_L) begin
                        good_d   = good_inc;
                        locked_d = (good_inc >= LOCK_L);
                        line_inc = !dec_v;
                    end else begin
                        len_err_d = 1'b1;
                        locked_d  = 1'b0;
                        good_d    = 16'd0;
                    end
                end
            end
        end

        if (line_clr)      line_d = 16'd0;
        else if (line_inc) line_d = line_q + 16'd1;
        else               line_d = line_q;
    end

    always_ff @(posedge i_SysClock) begin
        if (!i_ResetN) begin
            state_q    <= SEEK;
            data_q     <= 8'h00;
            dv_q       <= 1'b0;
            f_q        <= 1'b0;
            v_q        <= 1'b0;
            h_q        <= 1'b0;
            line_q     <= 16'd0;
            pix_q      <= 16'd0;
            good_q     <= 16'd0;
            locked_q   <= 1'b0;
            code_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            active_q   <= 1'b0;
            sav_v0_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            f_q        <= f_d;
            v_q        <= v_d;
            h_q        <= h_d;
            line_q     <= line_d;
            pix_q      <= pix_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            code_err_q <= code_err_d;
            len_err_q  <= len_err_d;
            active_q   <= active_d;
            sav_v0_q   <= sav_v0_d;
        end
    end

    assign o_Data       = data_q;
    assign o_DataValid  = dv_q;
    assign o_Fsignal    = f_q;
    assign o_Vsignal    = v_q;
    assign o_Hsignal    = h_q;
    assign o_LineCount  = line_q;
    assign o_PixelCount = pix_q;
    assign o_Locked     = locked_q;
    assign o_CodeError  = code_err_q;
    assign o_LenError   = len_err_q;
    assign o_TrsState   = state_q;

endmodule
